// File: rtl/alu_result_buffer_if.sv
// Handshake bundle between the ALU, the result buffer and the writeback consumer.
// The master side drives ALU results and consumer acceptance; the slave side is the buffer.
interface alu_result_buffer_if #(
    parameter int n     = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [n-1:0]     in_result;
    logic             in_carry;
    logic             in_overflow;
    logic             out_valid;
    logic             out_ready;
    logic [n-1:0]     out_result;
    logic             out_zero;
    logic             out_neg;
    logic             out_carry;
    logic             out_overflow;
    logic             clear_sticky;
    logic             ovf_sticky;
    logic [CNT_W-1:0] out_count;

    modport master (
        output in_valid, in_result, in_carry, in_overflow, out_ready, clear_sticky,
        input  in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
               out_overflow, ovf_sticky, out_count
    );

    modport slave (
        input  in_valid, in_result, in_carry, in_overflow, out_ready, clear_sticky,
        output in_ready, out_valid, out_result, out_zero, out_neg, out_carry,
               out_overflow, ovf_sticky, out_count
    );
endinterface

// File: rtl/alu_result_buffer.sv
// Two-entry skid FIFO behind the ALU: registers each result with zero/neg flags,
// tracks a sticky overflow bit and counts delivered results.
module alu_result_buffer #(
    parameter int n     = 32,
    parameter int CNT_W = 16
) (
    input logic                clk,
    input logic                reset,
    alu_result_buffer_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    typedef struct packed {
        logic [n-1:0] result;
        logic         zero;
        logic         neg;
        logic         carry;
        logic         overflow;
    } entry_t;

    state_t           state, state_next;
    entry_t           head, tail, incoming;
    logic             push, pop;
    logic             load_head_in, load_head_tail, load_tail;
    logic             sticky;
    logic [CNT_W-1:0] count;

    // Ready and valid come straight from the occupancy state, so in_ready never sees out_ready.
    assign bus.in_ready  = (state != TWO);
    assign bus.out_valid = (state != EMPTY);
    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_comb begin
        incoming.result   = bus.in_result;
        incoming.zero     = (bus.in_result == '0);
        incoming.neg      = bus.in_result[n-1];
        incoming.carry    = bus.in_carry;
        incoming.overflow = bus.in_overflow;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= EMPTY;
        else       state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_head_in   = 1'b0;
        load_head_tail = 1'b0;
        load_tail      = 1'b0;
        case (state)
            EMPTY: begin
                if (push) begin
                    state_next   = ONE;
                    load_head_in = 1'b1;
                end
            end
            ONE: begin
                if (push && pop) begin
                    load_head_in = 1'b1;
                end else if (push) begin
                    state_next = TWO;
                    load_tail  = 1'b1;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_next     = ONE;
                    load_head_tail = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (load_head_in)        head <= incoming;
            else if (load_head_tail) head <= tail;
            if (load_tail)           tail <= incoming;
        end
    end

    // A push carrying overflow beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
            count  <= '0;
        end else begin
            if (push && bus.in_overflow) sticky <= 1'b1;
            else if (bus.clear_sticky)   sticky <= 1'b0;
            if (pop) count <= count + 1'b1;
        end
    end

    assign bus.out_result   = head.result;
    assign bus.out_zero     = head.zero;
    assign bus.out_neg      = head.neg;
    assign bus.out_carry    = head.carry;
    assign bus.out_overflow = head.overflow;
    assign bus.ovf_sticky   = sticky;
    assign bus.out_count    = count;
endmodule
